// File: rtl/reg_file_access_ctrl_pkg.sv
// rtl/reg_file_access_ctrl_pkg.sv - shared widths and FSM encodings for the register file access controller
//
// Purpose : single source of truth for the default register data/address widths,
//           requester count and controller state encoding.
// Ports   : none (package).

package reg_file_access_ctrl_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_NUM_REQ    = 2;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_CAPTURE = 2'd3
    } rf_state_t;

endpackage

// File: rtl/reg_file_access_ctrl_if.sv
// rtl/reg_file_access_ctrl_if.sv - requester-side handshake bundle for one register file client
//
// Purpose : groups one requester's request/response signals.
// Signals : valid, we, addr_a, addr_b, wdata   requester -> controller
//           ready, rvalid, rdata_a, rdata_b     controller -> requester
// Modports: master (requester), slave (controller).

interface reg_file_access_ctrl_if
    import reg_file_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
);

    logic                  valid;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic [DATA_WIDTH-1:0] rdata_b;

    modport master (
        output valid, we, addr_a, addr_b, wdata,
        input  ready, rvalid, rdata_a, rdata_b
    );

    modport slave (
        input  valid, we, addr_a, addr_b, wdata,
        output ready, rvalid, rdata_a, rdata_b
    );

endinterface

// File: rtl/reg_file_access_ctrl_rr_arbiter_2.sv
// rtl/reg_file_access_ctrl_rr_arbiter_2.sv - two-way round-robin grant logic
//
// Purpose : grants at most one of two requesters, combinationally from valid and
//           an internal priority pointer; the pointer moves only when a grant is
//           taken.
// Ports   : clk, rst     clock, synchronous active-high reset
//           enable       grants allowed this cycle
//           valid[1:0]   request lines
//           grant[1:0]   one-hot (or zero) grant; a grant implies acceptance

module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    // Requester favoured when both are valid; 0 after reset.
    logic prio_q;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // After a grant to requester 0 favour requester 1, and vice versa. Lone
    // grants move the pointer too, so the next contention goes to the other side.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (|grant) begin
            prio_q <= grant[0];
        end
    end

endmodule

// File: rtl/reg_file_access_ctrl.sv
// rtl/reg_file_access_ctrl.sv - two-requester access controller for a 2R/1W register file
//
// Purpose : clears the register file after reset, then serves single read-pair or
//           write transactions from two requesters under round-robin arbitration.
// Ports   : clk, rst                      clock, synchronous active-high reset
//           req0, req1                    requester bundles (slave side)
//           rf_read, rf_write             register file strobes (never both high)
//           rf_addr_r1, rf_addr_r2        read addresses
//           rf_addr_w, rf_data_w          write address / data
//           rf_data_r1, rf_data_r2        read data, valid the cycle after rf_read
//           init_done                     high from the first IDLE cycle until reset
//
// Transaction timing (cycle 0 = cycle with valid & ready):
//   write: ISSUE in cycle 1 (rf_write), data present in the file from cycle 2.
//   read : ISSUE in cycle 1, CAPTURE in cycle 2, rvalid pulse in cycle 3.

module reg_file_access_ctrl
    import reg_file_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_file_access_ctrl_if.slave req0,
    reg_file_access_ctrl_if.slave req1,
    output logic                  rf_read,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_addr_r1,
    output logic [ADDR_WIDTH-1:0] rf_addr_r2,
    output logic [ADDR_WIDTH-1:0] rf_addr_w,
    output logic [DATA_WIDTH-1:0] rf_data_w,
    input  logic [DATA_WIDTH-1:0] rf_data_r1,
    input  logic [DATA_WIDTH-1:0] rf_data_r2,
    output logic                  init_done
);

    rf_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic                  init_done_q;

    logic [1:0] req_valid;
    logic [1:0] grant;
    logic       arb_en;
    logic       accept;
    logic       accept_id;

    // Registered copy of the accepted transaction.
    logic                  txn_we_q;
    logic                  txn_id_q;
    logic [ADDR_WIDTH-1:0] txn_addr_a_q;
    logic [ADDR_WIDTH-1:0] txn_addr_b_q;
    logic [DATA_WIDTH-1:0] txn_wdata_q;

    // Per-requester response registers.
    logic [1:0]                 rvalid_q;
    logic [1:0][DATA_WIDTH-1:0] rdata_a_q;
    logic [1:0][DATA_WIDTH-1:0] rdata_b_q;

    assign req_valid = {req1.valid, req0.valid};

    // No grant while reset is asserted, so nothing is accepted on the reset edge.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .enable (arb_en),
        .valid  (req_valid),
        .grant  (grant)
    );

    assign accept    = |grant;
    assign accept_id = grant[1];

    assign req0.ready   = grant[0];
    assign req1.ready   = grant[1];
    assign req0.rvalid  = rvalid_q[0];
    assign req1.rvalid  = rvalid_q[1];
    assign req0.rdata_a = rdata_a_q[0];
    assign req0.rdata_b = rdata_b_q[0];
    assign req1.rdata_a = rdata_a_q[1];
    assign req1.rdata_b = rdata_b_q[1];

    assign init_done = init_done_q;

    // Next state and register file strobes. Strobes are masked by rst so a
    // transaction caught by reset never reaches the register file on that edge.
    always_comb begin
        state_d    = state_q;
        rf_read    = 1'b0;
        rf_write   = 1'b0;
        rf_addr_r1 = '0;
        rf_addr_r2 = '0;
        rf_addr_w  = '0;
        rf_data_w  = '0;

        case (state_q)
            ST_INIT: begin
                rf_write  = !rst;
                rf_addr_w = init_cnt_q;
                if (init_cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (txn_we_q) begin
                    rf_write  = !rst;
                    rf_addr_w = txn_addr_a_q;
                    rf_data_w = txn_wdata_q;
                    state_d   = ST_IDLE;
                end else begin
                    rf_read    = !rst;
                    rf_addr_r1 = txn_addr_a_q;
                    rf_addr_r2 = txn_addr_b_q;
                    state_d    = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                // Addresses are held so the file output stays on the same pair.
                rf_read    = !rst;
                rf_addr_r1 = txn_addr_a_q;
                rf_addr_r2 = txn_addr_b_q;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            txn_we_q     <= 1'b0;
            txn_id_q     <= 1'b0;
            txn_addr_a_q <= '0;
            txn_addr_b_q <= '0;
            txn_wdata_q  <= '0;
            rvalid_q     <= '0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= '0;

            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
                if (state_d == ST_IDLE) begin
                    init_done_q <= 1'b1;
                end
            end

            if (accept) begin
                txn_id_q     <= accept_id;
                txn_we_q     <= accept_id ? req1.we     : req0.we;
                txn_addr_a_q <= accept_id ? req1.addr_a : req0.addr_a;
                txn_addr_b_q <= accept_id ? req1.addr_b : req0.addr_b;
                txn_wdata_q  <= accept_id ? req1.wdata  : req0.wdata;
            end

            // Read data only changes here, so each requester's rdata holds
            // until its own next read completes.
            if (state_q == ST_CAPTURE) begin
                rdata_a_q[txn_id_q] <= rf_data_r1;
                rdata_b_q[txn_id_q] <= rf_data_r2;
                rvalid_q[txn_id_q]  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_access_ctrl.sv
// tb/tb_reg_file_access_ctrl.sv - self-checking bench for reg_file_access_ctrl

module tb_reg_file_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  r_valid;
    logic [1:0]  r_we;
    logic [4:0]  r_addr_a [2];
    logic [4:0]  r_addr_b [2];
    logic [31:0] r_wdata  [2];

    reg_file_access_ctrl_if if0 ();
    reg_file_access_ctrl_if if1 ();

    assign if0.valid  = r_valid[0];
    assign if0.we     = r_we[0];
    assign if0.addr_a = r_addr_a[0];
    assign if0.addr_b = r_addr_b[0];
    assign if0.wdata  = r_wdata[0];
    assign if1.valid  = r_valid[1];
    assign if1.we     = r_we[1];
    assign if1.addr_a = r_addr_a[1];
    assign if1.addr_b = r_addr_b[1];
    assign if1.wdata  = r_wdata[1];

    logic [1:0]  ready_v;
    logic [1:0]  rvalid_v;
    logic [31:0] rdata_a_v [2];
    logic [31:0] rdata_b_v [2];

    assign ready_v      = {if1.ready, if0.ready};
    assign rvalid_v     = {if1.rvalid, if0.rvalid};
    assign rdata_a_v[0] = if0.rdata_a;
    assign rdata_a_v[1] = if1.rdata_a;
    assign rdata_b_v[0] = if0.rdata_b;
    assign rdata_b_v[1] = if1.rdata_b;

    logic        rf_read, rf_write, init_done;
    logic [4:0]  rf_addr_r1, rf_addr_r2, rf_addr_w;
    logic [31:0] rf_data_w, rf_data_r1, rf_data_r2;

    reg_file_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (if0),
        .req1       (if1),
        .rf_read    (rf_read),
        .rf_write   (rf_write),
        .rf_addr_r1 (rf_addr_r1),
        .rf_addr_r2 (rf_addr_r2),
        .rf_addr_w  (rf_addr_w),
        .rf_data_w  (rf_data_w),
        .rf_data_r1 (rf_data_r1),
        .rf_data_r2 (rf_data_r2),
        .init_done  (init_done)
    );

    // Register file: synchronous write, synchronous read; can be filled with junk.
    logic [31:0] tb_mem [32];
    logic        fill_en;
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= $urandom;
        end else if (rf_write) begin
            tb_mem[rf_addr_w] <= rf_data_w;
        end
        if (rf_read) begin
            rf_data_r1 <= tb_mem[rf_addr_r1];
            rf_data_r2 <= tb_mem[rf_addr_r2];
        end
    end

    // Reference contents: updated in order of acceptance.
    logic [31:0] model_mem [32];
    int          grant_log [$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rd_wr_exclusive", 64'(rf_read & rf_write), 64'd0);
            chk("ready_at_most_one", 64'(ready_v[0] & ready_v[1]), 64'd0);
        end
    end

    // Called at a falling edge; asserts reset for one rising edge and waits for init.
    task automatic do_reset();
        bit seq_ok, rv_seen, zero;
        int n;
        rst = 1'b1;
        r_valid = 2'b00;
        @(negedge clk);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_rvalid", 64'(rvalid_v), 64'd0);
        chk("rst_rdata", {rdata_a_v[0] | rdata_a_v[1], rdata_b_v[0] | rdata_b_v[1]}, 64'd0);
        rst = 1'b0;
        r_valid = 2'b11;
        #1;
        seq_ok = 1'b1; rv_seen = 1'b0; n = 0;
        while (init_done !== 1'b1 && n < 64) begin
            if (rf_write !== 1'b1 || rf_read !== 1'b0 || rf_addr_w !== n[4:0] ||
                rf_data_w !== 32'h0 || ready_v !== 2'b00) seq_ok = 1'b0;
            if (rvalid_v !== 2'b00) rv_seen = 1'b1;
            @(negedge clk); #1;
            n++;
        end
        r_valid = 2'b00;
        #1;
        chk("init_cycles", 64'(n), 64'd32);
        chk("init_sequence", 64'(seq_ok), 64'd1);
        chk("no_rvalid_after_reset", 64'(rv_seen), 64'd0);
        zero = 1'b1;
        for (int i = 0; i < 32; i++) if (tb_mem[i] !== 32'h0) zero = 1'b0;
        chk("rf_cleared", 64'(zero), 64'd1);
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
        mon_en = 1'b1;
    endtask

    // One transaction from requester id; checks latency, write visibility and read data.
    task automatic run_txn(input int id, input bit we, input int a, input int b,
                           input logic [31:0] d, output logic [31:0] got_a, output logic [31:0] got_b);
        int k, n;
        logic [31:0] ea, eb;
        got_a = 32'h0; got_b = 32'h0; ea = 32'h0; eb = 32'h0;
        r_we[id] = we; r_addr_a[id] = a[4:0]; r_addr_b[id] = b[4:0]; r_wdata[id] = d;
        r_valid[id] = 1'b1;
        #1;
        n = 0;
        while (ready_v[id] !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
        chk("accept", 64'(ready_v[id]), 64'd1);
        if (ready_v[id] !== 1'b1) begin r_valid[id] = 1'b0; return; end
        k = cyc;
        grant_log.push_back(id);
        if (we) model_mem[a] = d;
        else begin ea = model_mem[a]; eb = model_mem[b]; end
        @(negedge clk);
        r_valid[id] = 1'b0;
        if (we) begin
            @(negedge clk);
            chk("write_visible", 64'(tb_mem[a]), 64'(d));
        end else begin
            n = 0;
            while (rvalid_v[id] !== 1'b1 && n < 8) begin @(negedge clk); n++; end
            chk("rvalid_latency", 64'(cyc - k), 64'd3);
            got_a = rdata_a_v[id];
            got_b = rdata_b_v[id];
            chk("rdata_model", {got_a, got_b}, {ea, eb});
            @(negedge clk);
            chk("rvalid_pulse", 64'(rvalid_v[id]), 64'd0);
        end
    endtask

    typedef struct {
        int          id;
        bit          we;
        int          a;
        int          b;
        logic [31:0] d;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] ga0, gb0, ga1, gb1;
        int n;
        bit no_repeat;

        vecs[0] = '{0, 1'b1,  5,  0, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1] = '{0, 1'b0,  5,  0, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1, 1'b1, 31,  0, 32'hA5A50001, 32'h0,        32'h0};
        vecs[3] = '{1, 1'b0, 31,  5, 32'h0,        32'hA5A50001, 32'hDEADBEEF};
        vecs[4] = '{0, 1'b1,  0,  0, 32'hFFFFFFFF, 32'h0,        32'h0};
        vecs[5] = '{1, 1'b0,  0,  1, 32'h0,        32'hFFFFFFFF, 32'h0};
        vecs[6] = '{0, 1'b0,  2, 30, 32'h0,        32'h0,        32'h0};

        rst = 1'b1; fill_en = 1'b1; r_valid = 2'b00; r_we = 2'b00;
        for (int i = 0; i < 2; i++) begin
            r_addr_a[i] = 5'd0; r_addr_b[i] = 5'd0; r_wdata[i] = 32'h0;
        end
        @(negedge clk);
        fill_en = 1'b0;
        do_reset();

        // Every register reads 0 after the clear; requesters take turns.
        for (int i = 0; i < 16; i++) begin
            run_txn(i % 2, 1'b0, 2 * i, 2 * i + 1, 32'h0, ga0, gb0);
            chk("zero_read", {ga0, gb0}, 64'd0);
        end

        // Both requesters keep requesting: grants must alternate starting with 0.
        grant_log.delete();
        fork
            begin
                for (int i0 = 0; i0 < 4; i0++) run_txn(0, 1'b1, 10 + i0, 0, 32'h10000000 + i0, ga0, gb0);
            end
            begin
                for (int i1 = 0; i1 < 4; i1++) run_txn(1, 1'b1, 20 + i1, 0, 32'h20000000 + i1, ga1, gb1);
            end
        join
        chk("alt_count", 64'(grant_log.size()), 64'd8);
        no_repeat = 1'b1;
        for (int i = 0; i < grant_log.size(); i++) begin
            chk("alt_grant", 64'(grant_log[i]), 64'(i % 2));
            if (i > 0 && grant_log[i] == grant_log[i-1]) no_repeat = 1'b0;
        end
        chk("alt_no_repeat", 64'(no_repeat), 64'd1);

        // REQ1 reads R7 while REQ0 writes it; REQ0 is favoured so the read sees the new value.
        grant_log.delete();
        fork
            run_txn(0, 1'b1, 7, 0, 32'h12345678, ga0, gb0);
            run_txn(1, 1'b0, 7, 7, 32'h0, ga1, gb1);
        join
        chk("hazard_order", {32'(grant_log.size()), 16'(grant_log[0]), 16'(grant_log[1])}, {32'd2, 16'd0, 16'd1});
        chk("hazard_rdata", 64'(ga1), 64'h12345678);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].id, vecs[i].we, vecs[i].a, vecs[i].b, vecs[i].d, ga0, gb0);
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), {ga0, gb0}, {vecs[i].exp_a, vecs[i].exp_b});
        end

        // Random concurrent traffic against the reference contents.
        fork
            begin
                for (int i0 = 0; i0 < 12; i0++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    run_txn(0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                            int'($urandom_range(0, 31)), $urandom, ga0, gb0);
                end
            end
            begin
                for (int i1 = 0; i1 < 12; i1++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    run_txn(1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                            int'($urandom_range(0, 31)), $urandom, ga1, gb1);
                end
            end
        join

        // Reset during CAPTURE: read is dropped, clear reruns, old data is gone.
        run_txn(0, 1'b1, 9, 0, 32'hCAFEF00D, ga0, gb0);
        r_we[0] = 1'b0; r_addr_a[0] = 5'd9; r_addr_b[0] = 5'd9; r_valid[0] = 1'b1;
        #1;
        n = 0;
        while (ready_v[0] !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        chk("cap_accept", 64'(ready_v[0]), 64'd1);
        @(negedge clk);
        r_valid[0] = 1'b0;
        @(negedge clk);
        chk("cap_rf_read", 64'(rf_read), 64'd1);
        do_reset();
        run_txn(0, 1'b0, 9, 9, 32'h0, ga0, gb0);
        chk("cleared_after_reset", {ga0, gb0}, 64'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/reg_file_access_ctrl.md
REG_FILE_ACCESS_CTRL -- requirements
Module: reg_file_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width (32 registers).
REQ-003 SHALL have port CLK  in  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port RST  in  1  reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have ports REQn_VALID  in  1  transaction request, for n = 0, 1.
REQ-006 SHALL have ports REQn_WE  in  1  1 = write, 0 = read.
REQ-007 SHALL have ports REQn_ADDR_A / REQn_ADDR_B  in  ADDR_WIDTH  read addresses; ADDR_A is also the write address.
REQ-008 SHALL have ports REQn_WDATA  in  DATA_WIDTH  write data.
REQ-009 SHALL have ports REQn_READY  out  1  request accepted this cycle.
REQ-010 SHALL have ports REQn_RVALID  out  1  read data valid, one-cycle pulse.
REQ-011 SHALL have ports REQn_RDATA_A / REQn_RDATA_B  out  DATA_WIDTH  read results.
REQ-012 SHALL have ports RF_READ, RF_WRITE  out  1 each  register file strobes.
REQ-013 SHALL have ports RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W  out  ADDR_WIDTH  register file addresses.
REQ-014 SHALL have port RF_DATA_W  out  DATA_WIDTH; RF_DATA_R1, RF_DATA_R2  in  DATA_WIDTH.
REQ-015 SHALL have port INIT_DONE  out  1  high once the clear sequence has completed.

Function
REQ-016 SHALL implement FSM states INIT, IDLE, ISSUE, CAPTURE.
REQ-017 SHALL, in INIT, write 0 to R0..R31 in ascending order, one register per cycle (RF_WRITE=1, RF_READ=0), then go to IDLE after exactly 32 cycles.
REQ-018 SHALL hold both READY outputs low in every state except IDLE.
REQ-019 SHALL, in IDLE, raise READY of at most one requester, combinationally from VALID and the round-robin pointer; accept occurs on VALID&READY.
REQ-020 SHALL resolve simultaneous VALIDs by granting the requester not granted last; the pointer updates only on accept; after INIT the pointer favours requester 0.
REQ-021 SHALL grant a lone valid requester immediately, regardless of the pointer.
REQ-022 SHALL register the accepted opcode, addresses, write data and requester id on accept, then enter ISSUE.
REQ-023 SHALL, in ISSUE for a write, drive RF_WRITE=1, RF_ADDR_W=ADDR_A and RF_DATA_W=WDATA for one cycle, then return to IDLE.
REQ-024 SHALL, in ISSUE for a read, drive RF_READ=1, RF_ADDR_R1=ADDR_A and RF_ADDR_R2=ADDR_B, then enter CAPTURE.
REQ-025 SHALL, in CAPTURE, keep RF_READ=1, register RF_DATA_R1/R2 into the granted requester's RDATA_A/B, pulse its RVALID in the following cycle (IDLE), then stay in IDLE.
REQ-026 SHALL hold RDATA_A/B stable until that requester's next read completes.
REQ-027 SHALL never assert RF_READ and RF_WRITE together, and SHALL drive both low in IDLE.
REQ-028 SHALL have latencies from accept edge: write visible in the register file 2 cycles later; read RVALID 3 cycles later.
REQ-029 SHALL require requesters to hold VALID and payload stable until READY; payload changes before READY are not sampled.
REQ-030 SHALL assert INIT_DONE from the first IDLE cycle until the next reset.

Reset
REQ-031 SHALL, on RST=1 at a clock edge, enter INIT, restart the clear at R0, clear INIT_DONE, READY, RVALID, RDATA, RF strobes and addresses, and reset the pointer to requester 0.
REQ-032 SHALL abort any in-flight transaction when reset is asserted mid-operation: no RVALID and no further RF_WRITE for that transaction.

Structure
REQ-033 SHALL take DATA_WIDTH, ADDR_WIDTH and the FSM state encodings from the shared project definitions file.
REQ-034 SHALL place the two-way round-robin grant logic in one sub-module, RR_ARBITER_2.

Verification
REQ-035 SHALL cover reset release: INIT_DONE rises exactly 32 cycles after reset; reading R0..R31 then returns 0.
REQ-036 SHALL cover a REQ0 write of R5=0xDEADBEEF followed by a REQ0 read A=5, B=0: RVALID pulses 3 cycles after the read accept, with RDATA_A=0xDEADBEEF and RDATA_B=0.
REQ-037 SHALL cover both requesters holding VALID continuously: grants alternate 0,1,0,1, and no requester is granted twice in a row.
REQ-038 SHALL cover a REQ1 read of R7 while REQ0 writes R7=0x12345678 with REQ0 granted first: REQ1 RDATA_A equals 0x12345678.
REQ-039 SHALL cover RST pulsed during CAPTURE: no RVALID occurs, the FSM re-enters INIT, and a previously written value reads back 0 afterwards.
REQ-040 SHALL cover an assertion check over all tests: RF_READ and RF_WRITE are never both 1, and at most one READY is high.
